// File: rtl/deser_pkg.sv
// Shared constants and types for the byte-lane deserializer.
package deser_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;
    localparam int CNT_W  = $clog2(LANES);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } deser_state_t;

    typedef logic [LANES*LANE_W-1:0] word_t;

endpackage

// File: rtl/lane_demux_en.sv
// One-hot lane write-strobe decoder: selects exactly one lane when enabled.
module lane_demux_en #(
    parameter int LANES = 4,
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] sel,
    input  logic             en,
    output logic [LANES-1:0] strobe
);

    // Decode the lane index into a single write strobe, gated by en.
    always_comb begin
        strobe = {LANES{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            if (en && (sel == CNT_W'(i))) begin
                strobe[i] = 1'b1;
            end else begin
                strobe[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/byte_lane_deserializer.sv
// Byte stream to 32-bit word assembler with per-lane byte enables.
// Bytes fill lanes little-endian; a full word or an in_last beat completes it.
// A completed word goes straight to the output register when the slot is free,
// otherwise it is parked in the assembly register (HOLD) until the slot drains.
module byte_lane_deserializer
    import deser_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LANE_W-1:0]       in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [LANES*LANE_W-1:0] out_data,
    output logic [LANES-1:0]        out_byte_en,
    output logic                    out_valid,
    input  logic                    out_ready
);

    deser_state_t     state_r, state_s;
    logic [CNT_W-1:0] lane_cnt_r, lane_cnt_s;
    word_t            asm_data_r, asm_data_s;
    logic [LANES-1:0] asm_en_r, asm_en_s;
    word_t            out_data_r, out_data_s;
    logic [LANES-1:0] out_en_r, out_en_s;
    logic             out_valid_r, out_valid_s;

    logic             accept_s;
    logic             drain_s;
    logic             complete_s;
    logic             slot_free_s;
    logic [LANES-1:0] strobe_s;
    word_t            fill_data_s;
    logic [LANES-1:0] fill_en_s;

    // in_ready depends only on state and reset, never on out_ready.
    assign in_ready    = rst_n & (state_r == FILL);
    assign accept_s    = in_valid & in_ready;
    assign drain_s     = out_valid_r & out_ready;
    assign slot_free_s = ~out_valid_r | out_ready;
    assign complete_s  = accept_s & ((lane_cnt_r == CNT_W'(LANES - 1)) | in_last);

    assign out_data    = out_data_r;
    assign out_byte_en = out_en_r;
    assign out_valid   = out_valid_r;

    lane_demux_en #(
        .LANES (LANES),
        .CNT_W (CNT_W)
    ) u_lane_demux_en (
        .sel    (lane_cnt_r),
        .en     (accept_s),
        .strobe (strobe_s)
    );

    // Merge the incoming byte into the assembly word at its strobed lane.
    always_comb begin
        fill_data_s = asm_data_r;
        for (int i = 0; i < LANES; i++) begin
            if (strobe_s[i]) begin
                fill_data_s[i*LANE_W +: LANE_W] = in_data;
            end else begin
                fill_data_s[i*LANE_W +: LANE_W] = asm_data_r[i*LANE_W +: LANE_W];
            end
        end
        fill_en_s = asm_en_r | strobe_s;
    end

    // Next-state logic for the FILL/HOLD controller and its datapath registers.
    always_comb begin
        state_s     = state_r;
        lane_cnt_s  = lane_cnt_r;
        asm_data_s  = asm_data_r;
        asm_en_s    = asm_en_r;
        out_data_s  = out_data_r;
        out_en_s    = out_en_r;
        out_valid_s = out_valid_r;
        case (state_r)
            FILL: begin
                if (drain_s) begin
                    out_valid_s = 1'b0;
                end else begin
                    out_valid_s = out_valid_r;
                end
                if (complete_s) begin
                    lane_cnt_s = {CNT_W{1'b0}};
                    if (slot_free_s) begin
                        out_data_s  = fill_data_s;
                        out_en_s    = fill_en_s;
                        out_valid_s = 1'b1;
                        asm_data_s  = '0;
                        asm_en_s    = {LANES{1'b0}};
                    end else begin
                        asm_data_s = fill_data_s;
                        asm_en_s   = fill_en_s;
                        state_s    = HOLD;
                    end
                end else if (accept_s) begin
                    asm_data_s = fill_data_s;
                    asm_en_s   = fill_en_s;
                    lane_cnt_s = lane_cnt_r + CNT_W'(1);
                end else begin
                    lane_cnt_s = lane_cnt_r;
                end
            end
            HOLD: begin
                if (drain_s) begin
                    out_data_s  = asm_data_r;
                    out_en_s    = asm_en_r;
                    out_valid_s = 1'b1;
                    asm_data_s  = '0;
                    asm_en_s    = {LANES{1'b0}};
                    lane_cnt_s  = {CNT_W{1'b0}};
                    state_s     = FILL;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s     = FILL;
                lane_cnt_s  = {CNT_W{1'b0}};
                asm_data_s  = '0;
                asm_en_s    = {LANES{1'b0}};
                out_valid_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= FILL;
            lane_cnt_r  <= {CNT_W{1'b0}};
            asm_data_r  <= '0;
            asm_en_r    <= {LANES{1'b0}};
            out_data_r  <= '0;
            out_en_r    <= {LANES{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            lane_cnt_r  <= lane_cnt_s;
            asm_data_r  <= asm_data_s;
            asm_en_r    <= asm_en_s;
            out_data_r  <= out_data_s;
            out_en_r    <= out_en_s;
            out_valid_r <= out_valid_s;
        end
    end

endmodule

// File: tb/tb_byte_lane_deserializer.sv
// Self-checking bench: directed scenarios plus randomized handshakes, all
// compared against a word-level queue model of the byte stream.
module tb_byte_lane_deserializer;
    import deser_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_byte_en;
    logic        out_valid;
    logic        out_ready;

    byte_lane_deserializer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_byte_en (out_byte_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          accepted = 0;

    // Model: completed words not yet taken by the consumer, oldest first.
    logic [31:0] exp_w[$];
    logic [3:0]  exp_e[$];
    logic [31:0] cur_w = 32'h0;
    logic [3:0]  cur_e = 4'h0;
    int          cur_n = 0;

    logic [31:0] drained_w[$];
    logic [3:0]  drained_e[$];

    logic        stall_prev = 1'b0;
    logic [31:0] prev_d = 32'h0;
    logic [3:0]  prev_e = 4'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] last_word(input int back);
        if (drained_w.size() > back) return drained_w[drained_w.size()-1-back];
        return 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] last_en(input int back);
        if (drained_e.size() > back) return 32'(drained_e[drained_e.size()-1-back]);
        return 32'hxxxxxxxx;
    endfunction

    // One clock: drive inputs, check outputs against the model, then advance.
    task automatic cycle(input logic v, input logic [7:0] d, input logic l, input logic r);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        #1;
        if (!rst_n) begin
            check_eq("rst_in_ready", 32'(in_ready), 32'h0);
        end else begin
            check_eq("in_ready", 32'(in_ready), 32'(exp_w.size() < 2));
            check_eq("out_valid", 32'(out_valid), 32'(exp_w.size() > 0));
            if (stall_prev) begin
                check_eq("stall_data", out_data, prev_d);
                check_eq("stall_en", 32'(out_byte_en), 32'(prev_e));
            end
            if (out_valid && r) begin
                if (exp_w.size() > 0) begin
                    check_eq("word_data", out_data, exp_w[0]);
                    check_eq("word_en", 32'(out_byte_en), 32'(exp_e[0]));
                    void'(exp_w.pop_front());
                    void'(exp_e.pop_front());
                end
                drained_w.push_back(out_data);
                drained_e.push_back(out_byte_en);
            end
            if (v && in_ready) begin
                accepted++;
                cur_w[cur_n*8 +: 8] = d;
                cur_e[cur_n]        = 1'b1;
                cur_n++;
                if (cur_n == 4 || l) begin
                    exp_w.push_back(cur_w);
                    exp_e.push_back(cur_e);
                    cur_w = 32'h0;
                    cur_e = 4'h0;
                    cur_n = 0;
                end
            end
        end
        stall_prev = rst_n && out_valid && !r;
        prev_d     = out_data;
        prev_e     = out_byte_en;
        @(posedge clk);
        if (!rst_n) begin
            exp_w.delete();
            exp_e.delete();
            cur_w = 32'h0;
            cur_e = 4'h0;
            cur_n = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] b;
        int         n0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("reset_out_data", out_data, 32'h0);
        check_eq("reset_out_en", 32'(out_byte_en), 32'h0);
        check_eq("reset_out_valid", 32'(out_valid), 32'h0);
        rst_n = 1'b1;

        // Full word, consumer always ready.
        for (int i = 1; i <= 4; i++) begin
            b = 8'(i * 17);
            cycle(1'b1, b, 1'b0, 1'b1);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("t1_word", last_word(0), 32'h44332211);
        check_eq("t1_en", last_en(0), 32'hF);

        // Partial word closed by in_last.
        cycle(1'b1, 8'hAA, 1'b0, 1'b1);
        cycle(1'b1, 8'hBB, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("t2_word", last_word(0), 32'h0000BBAA);
        check_eq("t2_en", last_en(0), 32'h3);

        // in_last on the first byte gives a one-byte word.
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        cycle(1'b1, 8'h7F, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("t4_word", last_word(0), 32'h0000007F);
        check_eq("t4_en", last_en(0), 32'h1);

        // Back-pressure: second word parks in HOLD.
        for (int i = 1; i <= 8; i++) begin
            b = 8'(i);
            cycle(1'b1, b, 1'b0, 1'b0);
        end
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        check_eq("t3_hold_ready", 32'(in_ready), 32'h0);
        check_eq("t3_hold_data", out_data, 32'h04030201);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("t3_first", last_word(1), 32'h04030201);
        check_eq("t3_second", last_word(0), 32'h08070605);

        // Reset mid-word discards the partial word.
        n0 = drained_w.size();
        cycle(1'b1, 8'hC1, 1'b0, 1'b1);
        cycle(1'b1, 8'hC2, 1'b0, 1'b1);
        rst_n = 1'b0;
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("t5_rst_data", out_data, 32'h0);
        check_eq("t5_rst_en", 32'(out_byte_en), 32'h0);
        check_eq("t5_rst_valid", 32'(out_valid), 32'h0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            b = 8'(i);
            cycle(1'b1, b, 1'b0, 1'b1);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("t5_count", 32'(drained_w.size() - n0), 32'h1);
        check_eq("t5_word", last_word(0), 32'h04030201);

        // Randomized handshakes over 1000 accepted bytes.
        accepted = 0;
        for (int c = 0; c < 30000 && accepted < 1000; c++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0));
        end
        check_eq("rand_bound", 32'(accepted >= 1000), 32'h1);
        for (int c = 0; c < 4; c++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1);
        end
        check_eq("rand_all_drained", 32'(exp_w.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
